audio_period_sched: RTL

Period scheduler for the synth-to-host audio path. It sits between the host register bus and the synth voice loop, and sequences how many stereo samples are generated per host (JACK) period. It issues one fill trigger per qualifying voice-loop top until the programmed buffer size is reached, then closes the period on the host's cycle-end handshake. With buffer size 0 it falls back to free-running I2S mode, where the trigger follows lrck.

---
 rtl/audio_sched_pkg.sv | 17 +
 rtl/sched_edge_det.sv | 21 ++
 rtl/audio_period_sched.sv | 175 +++++++++++++++++
 3 files changed

// File: rtl/audio_sched_pkg.sv
// Shared register map and state encoding for the audio period scheduler.
package audio_sched_pkg;

  localparam logic [2:0] ADDR_CTRL    = 3'd2;
  localparam logic [2:0] ADDR_BUFSIZE = 3'd3;
  localparam logic [2:0] ADDR_RATE    = 3'd4;
  localparam logic [2:0] ADDR_STATUS  = 3'd5;
  localparam logic [2:0] ADDR_STATS   = 3'd6;

  typedef logic [1:0] sched_state_t;

  localparam sched_state_t ST_I2S      = 2'd0;
  localparam sched_state_t ST_IDLE     = 2'd1;
  localparam sched_state_t ST_FILL     = 2'd2;
  localparam sched_state_t ST_WAIT_END = 2'd3;

endpackage

// File: rtl/sched_edge_det.sv
// Start/end detector for the host "act" bit: one-cycle pulses on its rising
// and falling edges.
module sched_edge_det (
  input  logic clk,
  input  logic reset_n,
  input  logic i_act,
  output logic o_start,
  output logic o_end
);

  logic r_act_d;

  always_ff @(posedge clk) begin
    if (!reset_n) r_act_d <= 1'b0;
    else          r_act_d <= i_act;
  end

  assign o_start = i_act & ~r_act_d;
  assign o_end   = ~i_act & r_act_d;

endmodule

// File: rtl/audio_period_sched.sv
// Host-period sample scheduler: counts fill triggers per period, falls back to
// lrck-driven I2S when bufsize is 0. Define AUDIO_SCHED_STATS_EN for counters.
module audio_period_sched
  import audio_sched_pkg::*;
#(
  parameter int          FIFO_WIDTH   = 6,
  parameter logic [31:0] RATE_DEFAULT = 32'd48000
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [2:0]            address,
  input  logic                  write,
  input  logic                  read,
  input  logic [31:0]           datain,
  output logic [31:0]           dataout,
  input  logic                  lrck,
  input  logic                  xxxx_top,
  input  logic                  run,
  input  logic [FIFO_WIDTH:0]   fifo_level,
  output logic                  trig,
  output logic                  i2s_enable,
  output logic [31:0]           samplerate,
  output logic                  period_done,
  output logic                  underrun
);

  localparam int CW = FIFO_WIDTH + 1;
  localparam logic [CW-1:0] FIFO_LIMIT = {1'b1, {FIFO_WIDTH{1'b0}}};
  localparam logic [CW-1:0] ONE        = {{(CW-1){1'b0}}, 1'b1};

  logic              r_act;
  logic [CW-1:0]     r_bufsize;
  logic [CW-1:0]     r_bs_l;
  logic [CW-1:0]     r_count;
  logic [31:0]       r_rate;
  logic [31:0]       r_dataout;
  sched_state_t      r_state;
  logic              r_trig;
  logic              r_period_done;
  logic              r_underrun;

  logic              w_start;
  logic              w_end;
  logic              w_strobe_ok;
  logic              w_fill_close;
  logic              w_wait_close;
  logic [CW-1:0]     w_count_inc;
  logic [31:0]       w_rdata;

  sched_edge_det u_edge (
    .clk     (clk),
    .reset_n (reset_n),
    .i_act   (r_act),
    .o_start (w_start),
    .o_end   (w_end)
  );

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_act     <= 1'b0;
      r_bufsize <= '0;
      r_rate    <= RATE_DEFAULT;
    end else if (write) begin
      case (address)
        ADDR_CTRL:    r_act     <= datain[0];
        ADDR_BUFSIZE: r_bufsize <= datain[CW-1:0];
        ADDR_RATE:    r_rate    <= datain;
        default:      ;
      endcase
    end
  end

  // Closing events only count while a live (non-I2S) period is open.
  assign w_count_inc  = r_count + ONE;
  assign w_strobe_ok  = xxxx_top & ~run & (r_count < r_bs_l) & (fifo_level < FIFO_LIMIT);
  assign w_fill_close = (r_bufsize != '0) && (r_state == ST_FILL) && w_end;
  assign w_wait_close = (r_bufsize != '0) && (r_state == ST_WAIT_END) && w_end;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state       <= ST_IDLE;
      r_count       <= '0;
      r_bs_l        <= '0;
      r_trig        <= 1'b0;
      r_period_done <= 1'b0;
      r_underrun    <= 1'b0;
    end else begin
      r_trig        <= 1'b0;
      r_period_done <= 1'b0;
      // Clear first so a same-cycle underrun set below takes priority.
      if (write && address == ADDR_STATUS) r_underrun <= 1'b0;
      if (r_bufsize == '0) begin
        r_state <= ST_I2S;
        r_count <= '0;
      end else begin
        case (r_state)
          ST_I2S: r_state <= ST_IDLE;
          ST_IDLE: begin
            r_count <= '0;
            if (w_start) begin
              r_bs_l  <= r_bufsize;
              r_state <= ST_FILL;
            end
          end
          ST_FILL: begin
            if (w_fill_close) begin
              r_underrun    <= 1'b1;
              r_period_done <= 1'b1;
              r_count       <= '0;
              r_state       <= ST_IDLE;
            end else if (w_strobe_ok) begin
              r_trig  <= 1'b1;
              r_count <= w_count_inc;
              if (w_count_inc == r_bs_l) r_state <= ST_WAIT_END;
            end
          end
          ST_WAIT_END: begin
            if (w_wait_close) begin
              r_period_done <= 1'b1;
              r_count       <= '0;
              r_state       <= ST_IDLE;
            end
          end
          default: r_state <= ST_IDLE;
        endcase
      end
    end
  end

`ifdef AUDIO_SCHED_STATS_EN
  logic [15:0] r_period_cnt;
  logic [15:0] r_underrun_cnt;

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  always_ff @(posedge clk) begin
    if (!reset_n || (write && address == ADDR_STATS)) begin
      r_period_cnt   <= '0;
      r_underrun_cnt <= '0;
    end else begin
      if (w_fill_close || w_wait_close) r_period_cnt   <= sat_inc16(r_period_cnt);
      if (w_fill_close)                 r_underrun_cnt <= sat_inc16(r_underrun_cnt);
    end
  end
`endif

  always_comb begin
    w_rdata = '0;
    case (address)
      ADDR_CTRL:    w_rdata[0]        = r_act;
      ADDR_BUFSIZE: w_rdata[CW-1:0]   = r_bufsize;
      ADDR_RATE:    w_rdata           = r_rate;
      ADDR_STATUS:  w_rdata[CW+2:0]   = {r_underrun, r_state, r_count};
`ifdef AUDIO_SCHED_STATS_EN
      ADDR_STATS:   w_rdata           = {r_underrun_cnt, r_period_cnt};
`endif
      default:      ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n)  r_dataout <= '0;
    else if (read) r_dataout <= w_rdata;
  end

  assign dataout     = r_dataout;
  assign trig        = (r_state == ST_I2S) ? lrck : r_trig;
  assign i2s_enable  = (r_state == ST_I2S);
  assign samplerate  = r_rate;
  assign period_done = r_period_done;
  assign underrun    = r_underrun;

endmodule
